// File: rtl/sram_responder.sv
// ============================================================================
// Module   : sram_responder
// Purpose  : Wait-stated byte/half/word responder over an internal SRAM array.
//            Optional macro SRAM_INIT_CLEAR_EN zeroes the array after reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              fault
);

    localparam int c_DEPTH = 1 << (ADDR_W - 2);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT   = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
`ifdef SRAM_INIT_CLEAR_EN
    localparam logic [1:0] c_CLEAR  = 2'd3;
    localparam logic [1:0] c_RST_STATE = c_CLEAR;
    localparam logic [ADDR_W-3:0] c_CLR_LAST = '1;
    localparam logic [ADDR_W-3:0] c_CLR_ONE  = {{(ADDR_W-3){1'b0}}, 1'b1};
`else
    localparam logic [1:0] c_RST_STATE = c_IDLE;
`endif

    // Counter holds WAIT_STATES-1 so that WAIT lasts exactly WAIT_STATES cycles.
    localparam logic [3:0] c_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [1:0] c_ACCEPT_NEXT = (WAIT_STATES > 0) ? c_WAIT : c_ACCESS;

    logic [1:0]        r_state;
    logic [3:0]        r_wcnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic [31:0]       r_wdata;
    logic              r_rvalid;
    logic              r_fault;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [0:c_DEPTH-1];
`ifdef SRAM_INIT_CLEAR_EN
    logic [ADDR_W-3:0] r_clr_idx;
    logic              w_clr_we;
`endif

    logic              w_illegal;
    logic [ADDR_W-3:0] w_idx;
    logic [1:0]        w_lane;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_al;
    logic              w_mem_we;
    logic [31:0]       w_word;
    logic [31:0]       w_shift;
    logic [31:0]       w_rd;

    assign busy   = (r_state != c_IDLE);
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign fault  = r_fault;

    assign w_idx  = r_addr[ADDR_W-1:2];
    assign w_lane = r_addr[1:0];

    assign w_illegal = (r_size == 2'b11)
                    || ((r_size == 2'b01) && r_addr[0])
                    || ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));

    // Write data is replicated across lanes; byte enables pick the target.
    always_comb begin
        w_be       = 4'b0000;
        w_wdata_al = 32'd0;
        case (r_size)
            2'b00: begin
                w_be       = 4'b0001 << w_lane;
                w_wdata_al = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be       = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_al = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                w_be       = 4'b1111;
                w_wdata_al = r_wdata;
            end
            default: begin
                w_be       = 4'b0000;
                w_wdata_al = 32'd0;
            end
        endcase
    end

    assign w_mem_we = (r_state == c_ACCESS) && r_we && !w_illegal && !rst;

    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_lane, 3'b000};

    always_comb begin
        w_rd = 32'd0;
        case (r_size)
            2'b00:   w_rd = {24'd0, w_shift[7:0]};
            2'b01:   w_rd = {16'd0, w_shift[15:0]};
            2'b10:   w_rd = w_word;
            default: w_rd = 32'd0;
        endcase
    end

`ifdef SRAM_INIT_CLEAR_EN
    assign w_clr_we = (r_state == c_CLEAR) && !rst;
`endif

    // Array has no reset; rst gating above keeps an aborted write out.
    always_ff @(posedge clk) begin
`ifdef SRAM_INIT_CLEAR_EN
        if (w_clr_we) begin
            r_mem[r_clr_idx] <= 32'd0;
        end else
`endif
        if (w_mem_we) begin
            if (w_be[0]) r_mem[w_idx][7:0]   <= w_wdata_al[7:0];
            if (w_be[1]) r_mem[w_idx][15:8]  <= w_wdata_al[15:8];
            if (w_be[2]) r_mem[w_idx][23:16] <= w_wdata_al[23:16];
            if (w_be[3]) r_mem[w_idx][31:24] <= w_wdata_al[31:24];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_RST_STATE;
            r_wcnt   <= 4'd0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_size   <= 2'b00;
            r_wdata  <= 32'd0;
            r_rvalid <= 1'b0;
            r_fault  <= 1'b0;
            r_rdata  <= 32'd0;
`ifdef SRAM_INIT_CLEAR_EN
            r_clr_idx <= '0;
`endif
        end else begin
            r_rvalid <= 1'b0;
            r_fault  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_addr  <= addr;
                        r_size  <= size;
                        r_wdata <= wdata;
                        r_wcnt  <= c_WAIT_INIT;
                        r_state <= c_ACCEPT_NEXT;
                    end
                end
                c_WAIT: begin
                    if (r_wcnt == 4'd0) begin
                        r_state <= c_ACCESS;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                c_ACCESS: begin
                    r_rvalid <= 1'b1;
                    r_fault  <= w_illegal;
                    r_rdata  <= (w_illegal || r_we) ? 32'd0 : w_rd;
                    r_state  <= c_IDLE;
                end
`ifdef SRAM_INIT_CLEAR_EN
                c_CLEAR: begin
                    if (r_clr_idx == c_CLR_LAST) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_clr_idx <= r_clr_idx + c_CLR_ONE;
                    end
                end
`endif
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_responder.sv
// ============================================================================
// Module   : tb_sram_responder
// Purpose  : Directed bench for sram_responder at WAIT_STATES 0, 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_responder;

    localparam int AW = 6;
`ifdef SRAM_INIT_CLEAR_EN
    localparam logic C_RST_BUSY = 1'b1;
    localparam logic [31:0] C_PRIOR_AFTER_RST = 32'h0000_0000;
`else
    localparam logic C_RST_BUSY = 1'b0;
    localparam logic [31:0] C_PRIOR_AFTER_RST = 32'h0BAD_F00D;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req;
    logic          we;
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic [31:0]   wdata;
    logic [2:0]    busy;
    logic [2:0]    rvalid;
    logic [2:0]    fault;
    logic [31:0]   rdata [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Index 0: WAIT_STATES=0, index 1: WAIT_STATES=1, index 2: WAIT_STATES=3.
    sram_responder #(.ADDR_W(AW), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .req(req[0]), .we(we), .addr(addr), .size(size),
        .wdata(wdata), .busy(busy[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .fault(fault[0]));
    sram_responder #(.ADDR_W(AW), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .req(req[1]), .we(we), .addr(addr), .size(size),
        .wdata(wdata), .busy(busy[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .fault(fault[1]));
    sram_responder #(.ADDR_W(AW), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .req(req[2]), .we(we), .addr(addr), .size(size),
        .wdata(wdata), .busy(busy[2]), .rvalid(rvalid[2]), .rdata(rdata[2]), .fault(fault[2]));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int k);
        int t;
        t = 0;
        while (busy[k] && t < 100) begin
            tick();
            t++;
        end
        if (busy[k]) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle[%0d]: busy still %b after %0d cycles, required 0", k, busy[k], t);
        end
    endtask

    // Issues one request; lat counts edges from accept edge to the rvalid sample.
    task automatic do_txn(input int k, input logic w, input logic [AW-1:0] a,
                          input logic [1:0] s, input logic [31:0] d,
                          output logic [31:0] rd, output logic flt,
                          output int lat, output int bcnt);
        wait_idle(k);
        we = w; addr = a; size = s; wdata = d;
        req[k] = 1'b1;
        rd = 32'd0; flt = 1'b0; bcnt = 0;
        tick();
        req[k] = 1'b0;
        lat = 1;
        while (!rvalid[k] && lat < 40) begin
            if (busy[k]) bcnt++;
            tick();
            lat++;
        end
        if (rvalid[k]) begin
            rd  = rdata[k];
            flt = fault[k];
        end else begin
            lat = -1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({busy[k], rvalid[k], fault[k]} !== {C_RST_BUSY, 2'b00}) begin
                n_err++;
                $display("FAIL reset_flags[%0d]: busy/rvalid/fault=%b required %b", k,
                         {busy[k], rvalid[k], fault[k]}, {C_RST_BUSY, 2'b00});
            end
            n_cmp++;
            if (rdata[k] !== 32'd0) begin
                n_err++;
                $display("FAIL reset_rdata[%0d]: got %h required 00000000", k, rdata[k]);
            end
        end
        rst = 1'b0;
    endtask

`ifdef SRAM_INIT_CLEAR_EN
    task automatic test_clear;
        logic [31:0] rd; logic flt; int lat, bc, n;
        do_txn(1, 1'b1, 6'h3C, 2'b10, 32'hFFFF_FFFF, rd, flt, lat, bc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we = 1'b1; addr = 6'h3C; size = 2'b10; wdata = 32'h5555_5555;
        req[1] = 1'b1;
        n = 0;
        while (busy[1] && n < 40) begin
            n++;
            tick();
        end
        req[1] = 1'b0;
        n_cmp++;
        if (n !== 16) begin
            n_err++;
            $display("FAIL clear_busy_len: busy cycles %0d required 16", n);
        end
        n_cmp++;
        if (rvalid[1] !== 1'b0) begin
            n_err++;
            $display("FAIL clear_req_ignored: rvalid %b required 0", rvalid[1]);
        end
        do_txn(1, 1'b0, 6'h3C, 2'b10, 32'd0, rd, flt, lat, bc);
        n_cmp++;
        if (rd !== 32'h0000_0000 || lat !== 3) begin
            n_err++;
            $display("FAIL clear_read_3c: rdata %h lat %0d required 00000000 lat 3", rd, lat);
        end
    endtask
`endif

    task automatic test_word_rw;
        logic [31:0] rd; logic flt; int lat, bc;
        do_txn(1, 1'b1, 6'h10, 2'b10, 32'hDEAD_BEEF, rd, flt, lat, bc);
        n_cmp++;
        if (bc !== 2) begin
            n_err++;
            $display("FAIL word_wr_busy: busy cycles %0d required 2", bc);
        end
        n_cmp++;
        if (lat !== 3) begin
            n_err++;
            $display("FAIL word_wr_latency: rvalid at edge %0d required 3", lat);
        end
        n_cmp++;
        if ({busy[1], flt, rd} !== {1'b0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL word_wr_resp: busy %b fault %b rdata %h required 0 0 00000000",
                     busy[1], flt, rd);
        end
        do_txn(1, 1'b0, 6'h10, 2'b10, 32'd0, rd, flt, lat, bc);
        n_cmp++;
        if (rd !== 32'hDEAD_BEEF || flt !== 1'b0) begin
            n_err++;
            $display("FAIL word_rd: rdata %h fault %b required deadbeef 0", rd, flt);
        end
    endtask

    task automatic test_sizes;
        logic [31:0] rd; logic flt; int lat, bc;
        do_txn(1, 1'b1, 6'h11, 2'b00, 32'h0000_00AB, rd, flt, lat, bc);
        do_txn(1, 1'b0, 6'h10, 2'b10, 32'd0, rd, flt, lat, bc);
        n_cmp++;
        if (rd !== 32'hDEAD_ABEF) begin
            n_err++;
            $display("FAIL byte_wr_lane1: rdata %h required deadabef", rd);
        end
        do_txn(1, 1'b0, 6'h12, 2'b01, 32'd0, rd, flt, lat, bc);
        n_cmp++;
        if (rd !== 32'h0000_DEAD || flt !== 1'b0) begin
            n_err++;
            $display("FAIL half_rd_hi: rdata %h fault %b required 0000dead 0", rd, flt);
        end
        do_txn(1, 1'b0, 6'h13, 2'b00, 32'd0, rd, flt, lat, bc);
        n_cmp++;
        if (rd !== 32'h0000_00DE) begin
            n_err++;
            $display("FAIL byte_rd_lane3: rdata %h required 000000de", rd);
        end
        do_txn(1, 1'b1, 6'h12, 2'b01, 32'hFFFF_1234, rd, flt, lat, bc);
        do_txn(1, 1'b0, 6'h10, 2'b10, 32'd0, rd, flt, lat, bc);
        n_cmp++;
        if (rd !== 32'h1234_ABEF) begin
            n_err++;
            $display("FAIL half_wr_hi: rdata %h required 1234abef", rd);
        end
    endtask

    task automatic test_illegal;
        logic [31:0] rd; logic flt; int lat, bc;
        do_txn(1, 1'b1, 6'h00, 2'b10, 32'h1122_3344, rd, flt, lat, bc);
        do_txn(1, 1'b1, 6'h02, 2'b10, 32'h1234_5678, rd, flt, lat, bc);
        n_cmp++;
        if ({flt, rd} !== {1'b1, 32'd0} || lat !== 3) begin
            n_err++;
            $display("FAIL misaligned_word_wr: fault %b rdata %h lat %0d required 1 00000000 3",
                     flt, rd, lat);
        end
        tick();
        n_cmp++;
        if ({rvalid[1], fault[1]} !== 2'b00) begin
            n_err++;
            $display("FAIL fault_pulse_width: rvalid/fault %b required 00", {rvalid[1], fault[1]});
        end
        do_txn(1, 1'b0, 6'h00, 2'b10, 32'd0, rd, flt, lat, bc);
        n_cmp++;
        if (rd !== 32'h1122_3344 || flt !== 1'b0) begin
            n_err++;
            $display("FAIL no_write_on_fault: rdata %h fault %b required 11223344 0", rd, flt);
        end
        do_txn(1, 1'b0, 6'h00, 2'b11, 32'd0, rd, flt, lat, bc);
        n_cmp++;
        if ({flt, rd} !== {1'b1, 32'd0}) begin
            n_err++;
            $display("FAIL size11_rd: fault %b rdata %h required 1 00000000", flt, rd);
        end
        do_txn(1, 1'b0, 6'h01, 2'b01, 32'd0, rd, flt, lat, bc);
        n_cmp++;
        if ({flt, rd} !== {1'b1, 32'd0}) begin
            n_err++;
            $display("FAIL odd_half_rd: fault %b rdata %h required 1 00000000", flt, rd);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic flt; int lat, bc;
        logic [3:0]  bpat;
        do_txn(0, 1'b1, 6'h04, 2'b10, 32'hA5A5_A5A5, rd, flt, lat, bc);
        n_cmp++;
        if (lat !== 2 || bc !== 1) begin
            n_err++;
            $display("FAIL ws0_latency: lat %0d busy %0d required 2 1", lat, bc);
        end
        do_txn(0, 1'b1, 6'h08, 2'b10, 32'h5A5A_5A5A, rd, flt, lat, bc);
        wait_idle(0);
        we = 1'b0; size = 2'b10; addr = 6'h04;
        req[0] = 1'b1;
        tick();
        bpat[3] = busy[0];
        addr = 6'h08;
        tick();
        bpat[2] = busy[0];
        n_cmp++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'hA5A5_A5A5) begin
            n_err++;
            $display("FAIL b2b_first: rvalid %b rdata %h required 1 a5a5a5a5", rvalid[0], rdata[0]);
        end
        tick();
        bpat[1] = busy[0];
        addr = 6'h04;
        tick();
        bpat[0] = busy[0];
        req[0] = 1'b0;
        n_cmp++;
        if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h5A5A_5A5A) begin
            n_err++;
            $display("FAIL b2b_second: rvalid %b rdata %h required 1 5a5a5a5a", rvalid[0], rdata[0]);
        end
        n_cmp++;
        if (bpat !== 4'b1010) begin
            n_err++;
            $display("FAIL b2b_busy_pattern: %b required 1010", bpat);
        end
        tick();
        // req toggled low/high while the WS=3 instance is in WAIT must be dropped.
        wait_idle(2);
        we = 1'b0; size = 2'b10; addr = 6'h04;
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        tick();
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        lat = 0;
        while (!rvalid[2] && lat < 20) begin
            tick();
            lat++;
        end
        tick();
        tick();
        n_cmp++;
        if ({busy[2], rvalid[2]} !== 2'b00 || lat !== 2) begin
            n_err++;
            $display("FAIL req_while_busy: busy %b rvalid %b lat %0d required 0 0 2",
                     busy[2], rvalid[2], lat);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic flt; int lat, bc, seen;
        do_txn(2, 1'b1, 6'h20, 2'b10, 32'h0BAD_F00D, rd, flt, lat, bc);
        n_cmp++;
        if (lat !== 5 || bc !== 4) begin
            n_err++;
            $display("FAIL ws3_latency: lat %0d busy %0d required 5 4", lat, bc);
        end
        wait_idle(2);
        we = 1'b1; addr = 6'h20; size = 2'b10; wdata = 32'hCAFE_F00D;
        req[2] = 1'b1;
        tick();
        req[2] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({busy[2], rvalid[2]} !== {C_RST_BUSY, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset_state: busy %b rvalid %b required %b 0",
                     busy[2], rvalid[2], C_RST_BUSY);
        end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (rvalid[2]) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL mid_reset_no_rvalid: %0d rvalid pulses required 0", seen);
        end
        do_txn(2, 1'b0, 6'h20, 2'b10, 32'd0, rd, flt, lat, bc);
        n_cmp++;
        if (rd !== C_PRIOR_AFTER_RST || flt !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_no_commit: rdata %h fault %b required %h 0",
                     rd, flt, C_PRIOR_AFTER_RST);
        end
    endtask

    initial begin
        rst = 1'b1; req = 3'b000; we = 1'b0; addr = '0; size = 2'b00; wdata = 32'd0;
        test_reset();
`ifdef SRAM_INIT_CLEAR_EN
        test_clear();
`endif
        test_word_rw();
        test_sizes();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
